// File: rtl/up_count_mod.sv
// rtl/up_count_mod.sv - modulo-limit up counter with load, wrap pulse and sticky overflow
module up_count_mod #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_limit;
    logic             ovf_set;

    assign at_limit = (q_q == limit);

    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (at_limit) begin
                q_d    = '0;
                wrap_d = 1'b1;
            end else if (&q_q) begin
                // Only reachable when q sits above limit (loaded high or limit lowered).
                q_d     = '0;
                wrap_d  = 1'b1;
                ovf_set = 1'b1;
            end else begin
                q_d = q_q + ONE;
            end
        end
        ovf_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign tc   = at_limit;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_up_count_mod.sv
// tb/tb_up_count_mod.sv - randomized self-checking bench for up_count_mod
module tb_up_count_mod;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    int unsigned mq;
    bit          mwrap;
    bit          movf;

    up_count_mod #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH+2:0] expected_vec();
        logic [WIDTH-1:0] eq;
        eq = WIDTH'(mq);
        return {eq, mwrap, movf, (mq == int'(limit))};
    endfunction

    function automatic logic [WIDTH+2:0] actual_vec();
        return {q, wrap, ovf, tc};
    endfunction

    task automatic model_reset();
        mq    = 0;
        mwrap = 0;
        movf  = 0;
    endtask

    // Behavioural rules: count toward limit, anything past all-ones rolls over as an overflow.
    task automatic clock_and_model();
        bit set_ovf;
        @(posedge clk);
        set_ovf = 0;
        if (load) begin
            mq    = int'(load_val);
            mwrap = 0;
        end else if (en) begin
            if (mq == int'(limit)) begin
                mq    = 0;
                mwrap = 1;
            end else begin
                mq      = (mq + 1) % MODV;
                mwrap   = (mq == 0);
                set_ovf = (mq == 0);
            end
        end else begin
            mwrap = 0;
        end
        if (set_ovf) movf = 1;
        else if (clr_ovf) movf = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 0; en = 1; load = 0; load_val = '0; limit = 4'd9; clr_ovf = 0;
        model_reset();
        #10;
        checks++;
        if (actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL reset: {q,wrap,ovf,tc} got %b want %b", actual_vec(), expected_vec());
        end
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_count_limit9();
        int wraps = 0;
        limit = 4'd9; en = 1;
        for (int i = 0; i < 30; i++) begin
            clock_and_model();
            if (wrap === 1'b1) wraps++;
            checks++;
            if (actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL count9 cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
        checks++;
        if (wraps != 3) begin
            errors++;
            $display("FAIL count9 period: wraps got %0d want 3", wraps);
        end
    endtask

    task automatic test_free_run();
        limit = 4'd15; en = 1;
        for (int i = 0; i < 20; i++) begin
            clock_and_model();
            checks++;
            if (actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL freerun cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_overflow();
        limit = 4'd5; load = 1; load_val = 4'd12; en = 0;
        clock_and_model();
        load = 0; en = 1;
        for (int i = 0; i < 12; i++) begin
            clock_and_model();
            checks++;
            if (actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL overflow cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow sticky: ovf got %b want 1", ovf);
        end
    endtask

    task automatic test_clr_ovf();
        en = 0; clr_ovf = 1;
        clock_and_model();
        clr_ovf = 0;
        checks++;
        if (ovf !== 1'b0 || actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL clr_ovf: got %b want %b", actual_vec(), expected_vec());
        end
        load = 1; load_val = 4'd15;
        clock_and_model();
        load = 0; en = 1; clr_ovf = 1;
        clock_and_model();
        clr_ovf = 0;
        checks++;
        if (ovf !== 1'b1 || q !== 4'd0 || actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL set_wins: got %b want %b", actual_vec(), expected_vec());
        end
    endtask

    task automatic test_load_priority();
        load = 1; en = 1; load_val = 4'd3; limit = 4'd9;
        clock_and_model();
        load = 0;
        checks++;
        if (q !== 4'd3 || actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL load_prio: got %b want %b", actual_vec(), expected_vec());
        end
        en = 0;
        for (int i = 0; i < 5; i++) begin
            clock_and_model();
            checks++;
            if (q !== 4'd3 || wrap !== 1'b0 || actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL hold cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_limit_zero();
        load = 1; load_val = 4'd0; limit = 4'd0;
        clock_and_model();
        load = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            clock_and_model();
            checks++;
            if (q !== 4'd0 || wrap !== 1'b1 || actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL limit0 cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        clr_ovf = 0; limit = 4'd5; load = 1; load_val = 4'd15; en = 0;
        clock_and_model();
        load = 0; en = 1;
        clock_and_model();
        limit = 4'd12;
        for (int i = 0; i < 7; i++) clock_and_model();
        checks++;
        if (q !== 4'd7 || ovf !== 1'b1 || actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL pre_reset: got %b want %b", actual_vec(), expected_vec());
        end
        #2;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (actual_vec() !== expected_vec()) begin
            errors++;
            $display("FAIL async_reset: got %b want %b", actual_vec(), expected_vec());
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            clock_and_model();
            checks++;
            if (actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL resume cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = WIDTH'($urandom);
            clr_ovf  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) limit = WIDTH'($urandom);
            clock_and_model();
            checks++;
            if (actual_vec() !== expected_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", i, actual_vec(), expected_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_limit9();
        test_free_run();
        test_overflow();
        test_clr_ovf();
        test_load_priority();
        test_limit_zero();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
